hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised, sequential successor to the ID-stage stall controller for the 5-stage RV32 core. It tracks every in-flight register write with a per-register latency countdown and raises a stall in ID until each source operand can be forwarded. Supports single-cycle ALU ops, fixed-latency load and multiply, one outstanding variable-latency divide, flush squashing, and a saturating stall-cycle performance counter. Sits beside the ID stage and drives the same stall line into the IF/ID and ID/EX pipeline registers.

Parameters:
NUM_REGS, 32, architectural registers; register 0 is hardwired zero
ADDR_W, 5, register address width (clog2 NUM_REGS)
LOAD_LAT, 1, cycles a load result is unavailable for forwarding after issue
MUL_LAT, 2, cycles a multiply result is unavailable after issue
MAX_LAT, 4, largest fixed latency; counter width LAT_W = clog2(MAX_LAT+1)
CNT_W, 16, stall performance counter width

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
id_valid_ip  input  1  ID holds a valid instruction
id_src1_addr_ip  input  ADDR_W  rs1
id_src2_addr_ip  input  ADDR_W  rs2
id_src1_used_ip  input  1  instruction reads rs1
id_src2_used_ip  input  1  instruction reads rs2
id_rd_addr_ip  input  ADDR_W  destination register
id_write_en_ip  input  1  instruction writes rd
id_class_ip  input  2  00 ALU, 01 LOAD, 10 MUL, 11 DIV
flush_ip  input  1  squash instructions in ID and EX
div_done_ip  input  1  divider result written back this cycle
div_rd_ip  input  ADDR_W  destination of completing divide
stall_op  output  1  hold ID and IF this cycle
busy_vec_op  output  NUM_REGS  bit r = register r has a pending write
stall_count_op  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, active-high): all cnt[r]=0, div_pend[r]=0, div_busy=0, last_issue valid=0, stall_count_op=0; stall_op=0 and busy_vec_op=0 while reset is high.
- busy(r) = (cnt[r]!=0) | div_pend[r]; busy(0)=0 always. busy_vec_op reflects registered state, no same-cycle bypass.
- stall_op is combinational: id_valid_ip & !flush_ip & ( (src1_used & rs1!=0 & busy(rs1)) | (src2_used & rs2!=0 & busy(rs2)) | (class==DIV & div_busy) | (write_en & rd!=0 & div_pend[rd]) ). The last term is the WAW guard against a pending divide.
- Issue = id_valid_ip & !stall_op & !flush_ip.
- On issue with write_en & rd!=0: ALU sets nothing (result forwardable next cycle); LOAD sets cnt[rd]=max(cnt[rd]-1, LOAD_LAT); MUL likewise with MUL_LAT; DIV sets div_pend[rd]=1 and div_busy=1.
- Each cycle every nonzero cnt[r] not being written decrements by 1; issue write wins over decrement on the same register.
- div_done_ip: clears div_pend[div_rd_ip] and div_busy next edge. A div_done for a non-pending register is ignored, no error.
- Last-issue register: records valid, rd, class of each issue; cleared when there is no issue.
- flush_ip: no issue this cycle; if last-issue valid, clear cnt[last_rd] (LOAD/MUL) or div_pend[last_rd] and div_busy (DIV), killing the squashed EX instruction. Older entries are unaffected. Flush overrides decrement and div_done on the same register.
- stall_count_op increments on every cycle stall_op=1; it saturates at all-ones and never wraps.
- Reset mid-operation discards all pending state immediately.

Test Plan:
- LOAD x5 issued, next cycle ADD x6,x5,x1 in ID -> stall_op=1 for exactly 1 cycle (LOAD_LAT=1), then issues; stall_count_op=1.
- MUL x7 then SUB reading x7 -> stall_op high 2 cycles; busy_vec_op[7] falls on the cycle issue resumes.
- ALU chain ADDI x3 -> ADD x4,x3,x3 -> no stall; LOAD x0 followed by a reader of x0 -> no stall, busy_vec_op[0]=0.
- LOAD x9 issued, flush_ip next cycle -> cnt[9] cleared, a later reader of x9 does not stall; an older MUL x8 entry still stalls its reader.
- DIV x10 issued, second DIV in ID -> stall until div_done_ip with div_rd_ip=10; ADDI x10 in ID also stalls (WAW); reader of x10 released the cycle after div_done.
- Hold a stall condition with CNT_W=4 for 20 cycles -> stall_count_op reaches 15 and stays there; assert reset mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register latency countdowns, one outstanding
// divide, flush squashing of the instruction in EX, and a saturating stall counter.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 2,
  parameter int MAX_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid_ip,
  input  logic [ADDR_W-1:0]   id_src1_addr_ip,
  input  logic [ADDR_W-1:0]   id_src2_addr_ip,
  input  logic                id_src1_used_ip,
  input  logic                id_src2_used_ip,
  input  logic [ADDR_W-1:0]   id_rd_addr_ip,
  input  logic                id_write_en_ip,
  input  logic [1:0]          id_class_ip,
  input  logic                flush_ip,
  input  logic                div_done_ip,
  input  logic [ADDR_W-1:0]   div_rd_ip,
  output logic                stall_op,
  output logic [NUM_REGS-1:0] busy_vec_op,
  output logic [CNT_W-1:0]    stall_count_op
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LOAD_L   = LAT_W'(LOAD_LAT);
  localparam logic [LAT_W-1:0] MUL_L    = LAT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_MUL  = 2'b10,
    CLS_DIV  = 2'b11
  } op_class_t;

  logic [LAT_W-1:0]    cnt      [NUM_REGS];
  logic [LAT_W-1:0]    cnt_nxt  [NUM_REGS];
  logic [NUM_REGS-1:0] div_pend, div_pend_nxt;
  logic                div_busy, div_busy_nxt;
  logic                last_valid;
  logic [ADDR_W-1:0]   last_rd;
  op_class_t           last_class;
  logic [NUM_REGS-1:0] busy;
  op_class_t           id_class;
  logic                src1_haz, src2_haz, div_haz, waw_haz;
  logic                issue, issue_wr;

  // A rewritten fixed-latency register keeps whichever write finishes later.
  function automatic logic [LAT_W-1:0] lat_max(input logic [LAT_W-1:0] cur,
                                               input logic [LAT_W-1:0] lat);
    logic [LAT_W-1:0] dec;
    dec = (cur == '0) ? '0 : cur - LAT_ONE;
    return (dec > lat) ? dec : lat;
  endfunction

  assign id_class = op_class_t'(id_class_ip);

  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS; r++) busy[r] = (cnt[r] != '0) | div_pend[r];
  end

  assign busy_vec_op = busy;

  assign src1_haz = id_src1_used_ip & (id_src1_addr_ip != '0) & busy[id_src1_addr_ip];
  assign src2_haz = id_src2_used_ip & (id_src2_addr_ip != '0) & busy[id_src2_addr_ip];
  assign div_haz  = (id_class == CLS_DIV) & div_busy;
  assign waw_haz  = id_write_en_ip & (id_rd_addr_ip != '0) & div_pend[id_rd_addr_ip];

  assign stall_op = id_valid_ip & ~flush_ip & (src1_haz | src2_haz | div_haz | waw_haz);
  assign issue    = id_valid_ip & ~stall_op & ~flush_ip;
  assign issue_wr = issue & id_write_en_ip & (id_rd_addr_ip != '0);

  // Later assignments take priority: decrement < div_done < issue < flush.
  always_comb begin
    cnt_nxt      = cnt;
    div_pend_nxt = div_pend;
    div_busy_nxt = div_busy;
    for (int r = 0; r < NUM_REGS; r++)
      if (cnt[r] != '0) cnt_nxt[r] = cnt[r] - LAT_ONE;
    if (div_done_ip && div_pend[div_rd_ip]) begin
      div_pend_nxt[div_rd_ip] = 1'b0;
      div_busy_nxt            = 1'b0;
    end
    if (issue_wr) begin
      case (id_class)
        CLS_LOAD: cnt_nxt[id_rd_addr_ip] = lat_max(cnt[id_rd_addr_ip], LOAD_L);
        CLS_MUL:  cnt_nxt[id_rd_addr_ip] = lat_max(cnt[id_rd_addr_ip], MUL_L);
        CLS_DIV: begin
          div_pend_nxt[id_rd_addr_ip] = 1'b1;
          div_busy_nxt                = 1'b1;
        end
        default: ;
      endcase
    end
    if (flush_ip && last_valid) begin
      case (last_class)
        CLS_LOAD, CLS_MUL: cnt_nxt[last_rd] = '0;
        CLS_DIV: begin
          div_pend_nxt[last_rd] = 1'b0;
          div_busy_nxt          = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      div_pend <= '0;
      div_busy <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
      div_pend <= div_pend_nxt;
      div_busy <= div_busy_nxt;
    end
  end

  // Only issues that actually claimed a register are worth remembering, so a
  // flush can never clear an older entry on behalf of a non-writing instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_valid <= 1'b0;
      last_rd    <= '0;
      last_class <= CLS_ALU;
    end else begin
      last_valid <= issue_wr;
      last_rd    <= id_rd_addr_ip;
      last_class <= id_class;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count_op <= '0;
    else if (stall_op && (stall_count_op != '1))
      stall_count_op <= stall_count_op + CNT_ONE;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard; expectations come from a
// cycle-time model (ready-at timestamps per register) and are checked by a monitor.
module tb_hazard_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 2;
  localparam int MAX_LAT  = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                id_valid_ip = 1'b0;
  logic [ADDR_W-1:0]   id_src1_addr_ip = '0;
  logic [ADDR_W-1:0]   id_src2_addr_ip = '0;
  logic                id_src1_used_ip = 1'b0;
  logic                id_src2_used_ip = 1'b0;
  logic [ADDR_W-1:0]   id_rd_addr_ip = '0;
  logic                id_write_en_ip = 1'b0;
  logic [1:0]          id_class_ip = '0;
  logic                flush_ip = 1'b0;
  logic                div_done_ip = 1'b0;
  logic [ADDR_W-1:0]   div_rd_ip = '0;
  logic                stall_op;
  logic [NUM_REGS-1:0] busy_vec_op;
  logic [CNT_W-1:0]    stall_count_op;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .LOAD_LAT(LOAD_LAT),
    .MUL_LAT(MUL_LAT), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid_ip(id_valid_ip),
    .id_src1_addr_ip(id_src1_addr_ip), .id_src2_addr_ip(id_src2_addr_ip),
    .id_src1_used_ip(id_src1_used_ip), .id_src2_used_ip(id_src2_used_ip),
    .id_rd_addr_ip(id_rd_addr_ip), .id_write_en_ip(id_write_en_ip),
    .id_class_ip(id_class_ip), .flush_ip(flush_ip),
    .div_done_ip(div_done_ip), .div_rd_ip(div_rd_ip),
    .stall_op(stall_op), .busy_vec_op(busy_vec_op), .stall_count_op(stall_count_op)
  );

  typedef struct {
    logic                stall;
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    count;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Model: a register is busy while the current cycle is before its ready time.
  int ready_at[NUM_REGS];
  bit pend_m[NUM_REGS];
  bit div_busy_m;
  bit last_v;
  int last_rd;
  int last_cls;
  int now;
  int sc_m;

  function automatic bit model_busy(input int r);
    return (r != 0) && ((ready_at[r] > now) || pend_m[r]);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < NUM_REGS; r++) begin
      ready_at[r] = 0;
      pend_m[r]   = 1'b0;
    end
    div_busy_m = 1'b0;
    last_v     = 1'b0;
    last_rd    = 0;
    last_cls   = 0;
    now        = 0;
    sc_m       = 0;
  endtask

  task automatic applyStimulus(input bit v, input int rs1, input bit u1, input int rs2,
                               input bit u2, input int rd, input bit we, input int cls,
                               input bit fl, input bit done, input int drd);
    exp_t e;
    bit   stall_e;
    bit   issue;
    @(posedge clk);
    #1;
    id_valid_ip     = v;
    id_src1_addr_ip = ADDR_W'(rs1);
    id_src1_used_ip = u1;
    id_src2_addr_ip = ADDR_W'(rs2);
    id_src2_used_ip = u2;
    id_rd_addr_ip   = ADDR_W'(rd);
    id_write_en_ip  = we;
    id_class_ip     = 2'(cls);
    flush_ip        = fl;
    div_done_ip     = done;
    div_rd_ip       = ADDR_W'(drd);

    stall_e = v && !fl && ((u1 && model_busy(rs1)) || (u2 && model_busy(rs2)) ||
                           (cls == 3 && div_busy_m) || (we && rd != 0 && pend_m[rd]));
    e.stall = stall_e;
    for (int r = 0; r < NUM_REGS; r++) e.busy[r] = model_busy(r);
    e.count = CNT_W'(sc_m);
    exp_q.push_back(e);

    issue = v && !stall_e && !fl;
    if (done && pend_m[drd]) begin
      pend_m[drd] = 1'b0;
      div_busy_m  = 1'b0;
    end
    if (issue && we && rd != 0) begin
      case (cls)
        1: ready_at[rd] = imax(ready_at[rd], now + 1 + LOAD_LAT);
        2: ready_at[rd] = imax(ready_at[rd], now + 1 + MUL_LAT);
        3: begin
          pend_m[rd] = 1'b1;
          div_busy_m = 1'b1;
        end
        default: ;
      endcase
    end
    if (fl && last_v) begin
      if (last_cls == 1 || last_cls == 2) ready_at[last_rd] = 0;
      else if (last_cls == 3) begin
        pend_m[last_rd] = 1'b0;
        div_busy_m      = 1'b0;
      end
    end
    last_v   = issue && we && rd != 0;
    last_rd  = rd;
    last_cls = cls;
    if (stall_e && sc_m < CNT_MAX) sc_m++;
    now++;
  endtask

  task automatic instr(input int cls, input int rd, input int rs1, input int rs2);
    applyStimulus(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, cls, 1'b0, 1'b0, 0);
  endtask

  task automatic idleInputs();
    id_valid_ip = 1'b0; id_src1_used_ip = 1'b0; id_src2_used_ip = 1'b0;
    id_write_en_ip = 1'b0; flush_ip = 1'b0; div_done_ip = 1'b0;
    id_src1_addr_ip = '0; id_src2_addr_ip = '0; id_rd_addr_ip = '0;
    id_class_ip = '0; div_rd_ip = '0;
  endtask

  // Reset is raised between edges while inputs are still live, so the outputs
  // must fall asynchronously whatever ID is presenting.
  task automatic resetDut();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_stall", stall_op, 0);
    checkOutput("reset_busy", busy_vec_op, 0);
    checkOutput("reset_count", stall_count_op, 0);
    idleInputs();
    modelReset();
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("stall", stall_op, mon_e.stall);
        checkOutput("busy_vec", busy_vec_op, mon_e.busy);
        checkOutput("stall_count", stall_count_op, mon_e.count);
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pend_reg;
    bit v, fl, done;
    modelReset();
    resetDut();

    // Load-use: one stall cycle, then the reader issues.
    instr(1, 5, 0, 0);
    instr(0, 6, 5, 1);
    instr(0, 6, 5, 1);
    @(negedge clk); #1;
    checkOutput("load_use_count", stall_count_op, 1);

    // Multiply-use: two stall cycles, x7 free on the issuing cycle.
    resetDut();
    instr(2, 7, 0, 0);
    repeat (3) instr(0, 8, 7, 2);
    @(negedge clk); #1;
    checkOutput("mul_use_count", stall_count_op, 2);
    checkOutput("mul_busy7", busy_vec_op[7], 0);

    // ALU chain and x0 never stall.
    resetDut();
    instr(0, 3, 1, 2);
    instr(0, 4, 3, 3);
    instr(1, 0, 0, 0);
    instr(0, 5, 0, 0);
    @(negedge clk); #1;
    checkOutput("alu_x0_count", stall_count_op, 0);
    checkOutput("x0_busy", busy_vec_op[0], 0);

    // Flush kills the MUL in EX but not the older divide.
    resetDut();
    instr(3, 11, 0, 0);
    instr(2, 9, 0, 0);
    applyStimulus(1'b1, 9, 1'b1, 9, 1'b1, 12, 1'b1, 0, 1'b1, 1'b0, 0);
    instr(0, 13, 9, 0);
    @(negedge clk); #1;
    checkOutput("flush_x9_free", stall_op, 0);
    instr(0, 14, 11, 0);
    @(negedge clk); #1;
    checkOutput("flush_old_div", stall_op, 1);
    applyStimulus(1'b1, 11, 1'b1, 0, 1'b0, 14, 1'b1, 0, 1'b0, 1'b1, 11);
    instr(0, 14, 11, 0);

    // Divide: structural stall, WAW stall, release the cycle after done.
    resetDut();
    instr(3, 10, 0, 0);
    instr(3, 12, 1, 2);
    instr(0, 10, 1, 0);
    applyStimulus(1'b1, 10, 1'b1, 0, 1'b0, 15, 1'b1, 0, 1'b0, 1'b1, 10);
    instr(0, 15, 10, 0);
    @(negedge clk); #1;
    checkOutput("div_release", stall_op, 0);
    instr(3, 12, 1, 2);

    // Saturation, then reset while the stall is still active.
    resetDut();
    instr(3, 10, 0, 0);
    repeat (20) instr(0, 11, 10, 0);
    @(negedge clk); #1;
    checkOutput("sat_count", stall_count_op, 4'hF);
    checkOutput("sat_stall", stall_op, 1);
    resetDut();

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 7) != 0);
      fl = ($urandom_range(0, 9) == 0);
      pend_reg = 0;
      for (int r = 0; r < NUM_REGS; r++) if (pend_m[r]) pend_reg = r;
      if (div_busy_m) done = ($urandom_range(0, 3) == 0);
      else begin
        done = ($urandom_range(0, 15) == 0);
        pend_reg = $urandom_range(0, 7);
      end
      applyStimulus(v, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
                    $urandom_range(0, 3), fl, done, pend_reg);
    end

    repeat (3) @(negedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
